rv32i_instr_decode: RTL and testbench
=====================================

Name: rv32i_instr_decode

Overview:
- RV32I decode stage: takes a 32-bit instruction, drives the two register-file read addresses, and captures the decoded control flags, operands, destination and branch target in one register stage for execute/memory.
- Sits between fetch and execute. Reads the architectural register file (asynchronous read) through the raddr/rdata pairs.
- Has no PC input, so PC-relative targets are passed on as offsets.

Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous reset, active low
- instr  in  32  instruction word
- rdata1  in  32  register-file read data for raddr1
- rdata2  in  32  register-file read data for raddr2
- raddr1  out  5  rs1 address, combinational
- raddr2  out  5  rs2 address, combinational
- is_store  out  1  STORE decoded
- is_load  out  1  LOAD decoded
- is_branch  out  1  conditional branch decoded
- is_jump  out  1  JAL/JALR decoded
- is_reg  out  1  instruction writes rd
- is_alu  out  1  result comes from the ALU
- operand_a  out  32  first operand
- operand_b  out  32  second operand
- branch_dest  out  32  branch/jump target information
- dest  out  5  rd address
- func3  out  3  instr[14:12] (or a forced value, see below)
- func7  out  1  ALU modifier bit instr[30]

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-low.
- Reset: on a clk edge with reset=0, every registered output clears to 0. While reset=0, raddr1 and raddr2 are forced to 0 combinationally.
- Latency: all outputs except raddr1/raddr2 update on the rising edge one cycle after instr and rdata are presented. rdata is sampled in the same cycle as the raddr it answers.
- raddr1 = instr[19:15] for R, I-ALU, LOAD, STORE, BRANCH and JALR; otherwise 0.
- raddr2 = instr[24:20] for R, STORE and BRANCH; otherwise 0.
- Immediates are sign-extended from instr[31]:
  - imm_i = instr[31:20]
  - imm_s = {instr[31:25], instr[11:7]}
  - imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - imm_u = {instr[31:12], 12'b0}
  - imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- Opcode decode, instr[6:0]. Any output not listed for an opcode is 0.
  - 0110011 (R-type): is_alu, is_reg; a=rdata1, b=rdata2; dest=rd; func3; func7=instr[30].
  - 0010011 (I-ALU): is_alu, is_reg; a=rdata1, b=imm_i; dest=rd; func3. func7=instr[30] only when func3=101, else 0.
  - 0110111 (LUI): is_alu, is_reg; a=0, b=imm_u; func3=000; dest=rd.
  - 0010111 (AUIPC): is_alu, is_reg; a=0, b=imm_u; branch_dest=imm_u (PC-relative offset); func3=000; dest=rd.
  - 0000011 (LOAD): is_load, is_reg; a=rdata1+imm_i (effective address), b=0; func3=width; dest=rd.
  - 0100011 (STORE): is_store; a=rdata1+imm_s, b=rdata2 (store data); func3=width; dest=0.
  - 1100011 (BRANCH): is_branch; a=rdata1, b=rdata2; func3; branch_dest=imm_b (PC-relative offset).
  - 1101111 (JAL): is_jump, is_reg; dest=rd; branch_dest=imm_j (PC-relative); a=0, b=0.
  - 1100111 (JALR): is_jump, is_reg; dest=rd; branch_dest=(rdata1+imm_i) with bit0 cleared (absolute); a=0, b=1 (absolute-target marker).
  - FENCE, SYSTEM, illegal or unknown opcodes: all outputs 0 (NOP bubble).
- Arithmetic: additions are 32-bit modulo 2^32 and wrap silently. rd=x0 is passed through unchanged (the register file ignores writes to x0).
- Reset asserted mid-stream: the next edge clears the outputs regardless of instr. Decoding resumes on the first edge after reset returns high.

Test Plan:
- Hold reset=0 for 2 edges with instr=0xFFFFFFFF -> every output, including raddr1/raddr2, equals 0.
- x1=5, x2=7; instr=0x002081B3 (add x3,x1,x2); one edge -> is_alu=1, is_reg=1, a=5, b=7, dest=3, func3=0, func7=0, raddr1=1, raddr2=2.
- x1=0x100; instr=0xFFC0A183 (lw x3,-4(x1)) -> is_load=1, is_reg=1, a=0xFC, func3=010, dest=3.
- x1=3, x2=3; instr=0xFE208EE3 (beq x1,x2,-4) -> is_branch=1, a=3, b=3, func3=0, branch_dest=0xFFFFFFFC, is_reg=0.
- x1=0x1001; instr=0x004080E7 (jalr x1,4(x1)) -> is_jump=1, is_reg=1, dest=1, branch_dest=0x1004, b=1. Then instr=0x0000006F (jal x0,0) -> branch_dest=0, b=0.
- instr=0x40105193 (srai x3,x0,1) -> func7=1, func3=101. Then instr=0x00000073 (ecall) -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/rv32i_instr_decode.sv
// RV32I decode stage: drives register-file read addresses combinationally and
// registers the decoded control flags, operands, destination and target info.
module rv32i_instr_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  output logic [4:0]  raddr1,
  output logic [4:0]  raddr2,
  output logic        is_store,
  output logic        is_load,
  output logic        is_branch,
  output logic        is_jump,
  output logic        is_reg,
  output logic        is_alu,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [31:0] branch_dest,
  output logic [4:0]  dest,
  output logic [2:0]  func3,
  output logic        func7
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic            is_store;
    logic            is_load;
    logic            is_branch;
    logic            is_jump;
    logic            is_reg;
    logic            is_alu;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [XLEN-1:0] branch_dest;
    logic [RW-1:0]   dest;
    logic [2:0]      func3;
    logic            func7;
  } decoded_t;

  decoded_t dec_d, dec_q;

  logic [6:0]      opcode;
  logic [RW-1:0]   rd;
  logic [RW-1:0]   rs1;
  logic [RW-1:0]   rs2;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] jalr_sum;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign jalr_sum = rdata1 + imm_i;

  // Register-file read addresses; forced to x0 while reset is held low.
  always_comb begin
    raddr1 = '0;
    raddr2 = '0;
    if (reset) begin
      unique case (opcode)
        OP_R, OP_STORE, OP_BRANCH: begin
          raddr1 = rs1;
          raddr2 = rs2;
        end
        OP_I_ALU, OP_LOAD, OP_JALR: raddr1 = rs1;
        default: ;
      endcase
    end
  end

  // Opcode decode into the next pipeline payload; unknown opcodes become a bubble.
  always_comb begin
    dec_d = '0;
    unique case (opcode)
      OP_R: begin
        dec_d.is_alu    = 1'b1;
        dec_d.is_reg    = 1'b1;
        dec_d.operand_a = rdata1;
        dec_d.operand_b = rdata2;
        dec_d.dest      = rd;
        dec_d.func3     = f3;
        dec_d.func7     = instr[30];
      end
      OP_I_ALU: begin
        dec_d.is_alu    = 1'b1;
        dec_d.is_reg    = 1'b1;
        dec_d.operand_a = rdata1;
        dec_d.operand_b = imm_i;
        dec_d.dest      = rd;
        dec_d.func3     = f3;
        // Only the shift-right immediates carry a meaningful bit 30.
        dec_d.func7     = (f3 == 3'b101) ? instr[30] : 1'b0;
      end
      OP_LUI: begin
        dec_d.is_alu    = 1'b1;
        dec_d.is_reg    = 1'b1;
        dec_d.operand_b = imm_u;
        dec_d.dest      = rd;
      end
      OP_AUIPC: begin
        dec_d.is_alu      = 1'b1;
        dec_d.is_reg      = 1'b1;
        dec_d.operand_b   = imm_u;
        dec_d.branch_dest = imm_u;
        dec_d.dest        = rd;
      end
      OP_LOAD: begin
        dec_d.is_load   = 1'b1;
        dec_d.is_reg    = 1'b1;
        dec_d.operand_a = rdata1 + imm_i;
        dec_d.dest      = rd;
        dec_d.func3     = f3;
      end
      OP_STORE: begin
        dec_d.is_store  = 1'b1;
        dec_d.operand_a = rdata1 + imm_s;
        dec_d.operand_b = rdata2;
        dec_d.func3     = f3;
      end
      OP_BRANCH: begin
        dec_d.is_branch   = 1'b1;
        dec_d.operand_a   = rdata1;
        dec_d.operand_b   = rdata2;
        dec_d.func3       = f3;
        dec_d.branch_dest = imm_b;
      end
      OP_JAL: begin
        dec_d.is_jump     = 1'b1;
        dec_d.is_reg      = 1'b1;
        dec_d.dest        = rd;
        dec_d.branch_dest = imm_j;
      end
      OP_JALR: begin
        // operand_b = 1 tells execute the target is absolute, not PC-relative.
        dec_d.is_jump     = 1'b1;
        dec_d.is_reg      = 1'b1;
        dec_d.dest        = rd;
        dec_d.branch_dest = {jalr_sum[XLEN-1:1], 1'b0};
        dec_d.operand_b   = XLEN'(1);
      end
      default: ;
    endcase
  end

  // Decode pipeline register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) dec_q <= '0;
    else        dec_q <= dec_d;
  end

  assign is_store    = dec_q.is_store;
  assign is_load     = dec_q.is_load;
  assign is_branch   = dec_q.is_branch;
  assign is_jump     = dec_q.is_jump;
  assign is_reg      = dec_q.is_reg;
  assign is_alu      = dec_q.is_alu;
  assign operand_a   = dec_q.operand_a;
  assign operand_b   = dec_q.operand_b;
  assign branch_dest = dec_q.branch_dest;
  assign dest        = dec_q.dest;
  assign func3       = dec_q.func3;
  assign func7       = dec_q.func7;

endmodule

// File: tb/tb_rv32i_instr_decode.sv
// Self-checking bench for rv32i_instr_decode: register-file model on the read
// ports, expected decode results queued at drive time and compared after the edge.
module tb_rv32i_instr_decode;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic [31:0] rdata1, rdata2;
  logic [4:0]  raddr1, raddr2;
  logic        is_store, is_load, is_branch, is_jump, is_reg, is_alu;
  logic [31:0] operand_a, operand_b, branch_dest;
  logic [4:0]  dest;
  logic [2:0]  func3;
  logic        func7;

  logic [31:0] rf [32];

  typedef struct {
    logic [5:0]  flags;  // {store, load, branch, jump, reg, alu}
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] bd;
    logic [4:0]  dest;
    logic [2:0]  f3;
    logic        f7;
  } exp_t;

  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;

  rv32i_instr_decode dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .rdata1      (rdata1),
    .rdata2      (rdata2),
    .raddr1      (raddr1),
    .raddr2      (raddr2),
    .is_store    (is_store),
    .is_load     (is_load),
    .is_branch   (is_branch),
    .is_jump     (is_jump),
    .is_reg      (is_reg),
    .is_alu      (is_alu),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .branch_dest (branch_dest),
    .dest        (dest),
    .func3       (func3),
    .func7       (func7)
  );

  // Asynchronous-read register file.
  assign rdata1 = rf[raddr1];
  assign rdata2 = rf[raddr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one instruction, check read addresses, queue the expectation, then
  // compare the registered outputs after the next rising edge.
  task automatic send(input string tag, input logic rst_v, input logic [31:0] i,
                      input logic [4:0] ra1, input logic [4:0] ra2,
                      input logic [5:0] flags, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] bd,
                      input logic [4:0] d, input logic [2:0] f3, input logic f7);
    exp_t e;
    exp_t got;
    @(negedge clk);
    reset = rst_v;
    instr = i;
    #1;
    check({tag, ".raddr1"}, 32'(raddr1), 32'(ra1));
    check({tag, ".raddr2"}, 32'(raddr2), 32'(ra2));
    e.flags = flags; e.a = a; e.b = b; e.bd = bd; e.dest = d; e.f3 = f3; e.f7 = f7;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'(1), 32'(0));
    end else begin
      got = sb_q.pop_front();
      check({tag, ".flags"},  32'({is_store, is_load, is_branch, is_jump, is_reg, is_alu}), 32'(got.flags));
      check({tag, ".op_a"},   operand_a,   got.a);
      check({tag, ".op_b"},   operand_b,   got.b);
      check({tag, ".bdest"},  branch_dest, got.bd);
      check({tag, ".dest"},   32'(dest),   32'(got.dest));
      check({tag, ".func3"},  32'(func3),  32'(got.f3));
      check({tag, ".func7"},  32'(func7),  32'(got.f7));
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) rf[k] = 32'h0;
    reset = 1'b0;
    instr = 32'hFFFF_FFFF;

    // Reset held for two edges with an all-ones instruction.
    send("rst0", 1'b0, 32'hFFFF_FFFF, 5'd0, 5'd0, 6'b000000, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0);
    send("rst1", 1'b0, 32'hFFFF_FFFF, 5'd0, 5'd0, 6'b000000, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0);

    rf[1] = 32'd5; rf[2] = 32'd7;
    send("add",  1'b1, 32'h0020_81B3, 5'd1, 5'd2, 6'b000011, 32'd5, 32'd7, 32'h0, 5'd3, 3'd0, 1'b0);
    send("sub",  1'b1, 32'h4020_8233, 5'd1, 5'd2, 6'b000011, 32'd5, 32'd7, 32'h0, 5'd4, 3'd0, 1'b1);

    rf[1] = 32'h100;
    send("lw",   1'b1, 32'hFFC0_A183, 5'd1, 5'd0, 6'b010010, 32'hFC, 32'h0, 32'h0, 5'd3, 3'd2, 1'b0);
    // addi with bit 30 set but func3 != 101: func7 stays 0, rs2 field not read
    send("addi", 1'b1, 32'hC1F0_8293, 5'd1, 5'd0, 6'b000011, 32'h100, 32'hFFFF_FC1F, 32'h0, 5'd5, 3'd0, 1'b0);

    rf[1] = 32'd3; rf[2] = 32'd3;
    send("beq",  1'b1, 32'hFE20_8EE3, 5'd1, 5'd2, 6'b001000, 32'd3, 32'd3, 32'hFFFF_FFFC, 5'd0, 3'd0, 1'b0);

    rf[1] = 32'h1001;
    send("jalr", 1'b1, 32'h0040_80E7, 5'd1, 5'd0, 6'b000110, 32'h0, 32'h1, 32'h1004, 5'd1, 3'd0, 1'b0);
    send("jal",  1'b1, 32'h0000_006F, 5'd0, 5'd0, 6'b000110, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0);

    send("srai", 1'b1, 32'h4010_5193, 5'd0, 5'd0, 6'b000011, 32'h0, 32'h401, 32'h0, 5'd3, 3'd5, 1'b1);
    send("ecall",1'b1, 32'h0000_0073, 5'd0, 5'd0, 6'b000000, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0);

    // Store address wraps modulo 2^32.
    rf[1] = 32'hFFFF_FFFE; rf[2] = 32'hDEAD_BEEF;
    send("sw",   1'b1, 32'h0020_A223, 5'd1, 5'd2, 6'b100000, 32'h2, 32'hDEAD_BEEF, 32'h0, 5'd0, 3'd2, 1'b0);

    // LUI/AUIPC force func3 to 000 and func7 to 0 whatever the raw bits.
    send("lui",  1'b1, 32'h1234_53B7, 5'd0, 5'd0, 6'b000011, 32'h0, 32'h1234_5000, 32'h0, 5'd7, 3'd0, 1'b0);
    send("auipc",1'b1, 32'hFFFF_F497, 5'd0, 5'd0, 6'b000011, 32'h0, 32'hFFFF_F000, 32'hFFFF_F000, 5'd9, 3'd0, 1'b0);
    send("fence",1'b1, 32'h0FF0_000F, 5'd0, 5'd0, 6'b000000, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0);

    // Reset asserted mid-stream, then decoding resumes.
    rf[1] = 32'd5; rf[2] = 32'd7;
    send("add_pre", 1'b1, 32'h0020_81B3, 5'd1, 5'd2, 6'b000011, 32'd5, 32'd7, 32'h0, 5'd3, 3'd0, 1'b0);
    send("rst_mid", 1'b0, 32'h0020_81B3, 5'd0, 5'd0, 6'b000000, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0);
    send("add_post",1'b1, 32'h0020_81B3, 5'd1, 5'd2, 6'b000011, 32'd5, 32'd7, 32'h0, 5'd3, 3'd0, 1'b0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
